// File: rtl/ftdi_rx_async.sv
`default_nettype none
// ============================================================================
//  Module      : ftdi_rx_async
//  Description : FT245-style asynchronous FIFO receive path. Watches RXF#,
//                requests the shared FTDI data bus from the transmit path,
//                runs the RD# strobe handshake and stores each byte in a
//                local first-word-fall-through FIFO. Never drives the bus.
//  Ports       : iClk/iRst       - clock, synchronous active-high reset
//                iFifoData       - FTDI data bus (input side of tristate)
//                iRxF_n          - FTDI "receive data available", async
//                oRx_n           - RD# strobe, active low
//                oBusReq/iBusGnt - bus ownership handshake with TX path
//                oRxData/oRxValid/iRxReady - FWFT byte stream to fabric
//                oRxLevel        - bytes currently held in the FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module ftdi_rx_async #(
  parameter int pDataWidth    = 8,
  parameter int pDepth        = 16,
  parameter int pRdLowCycles  = 3,
  parameter int pRdHighCycles = 3
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [pDataWidth-1:0]   iFifoData,
  input  logic                    iRxF_n,
  output logic                    oRx_n,
  output logic                    oBusReq,
  input  logic                    iBusGnt,
  output logic [pDataWidth-1:0]   oRxData,
  output logic                    oRxValid,
  input  logic                    iRxReady,
  output logic [$clog2(pDepth):0] oRxLevel
);

  localparam int ADDR_W  = $clog2(pDepth);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int CNT_MAX = (pRdLowCycles > pRdHighCycles) ? pRdLowCycles : pRdHighCycles;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RD_LOW  = 2'd2;
  localparam logic [1:0] ST_RD_HIGH = 2'd3;

  logic                  rxf_meta;
  logic                  rxf_s;
  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [pDataWidth-1:0] mem [pDepth];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      level;
  logic                  push;
  logic                  pop;
  logic                  has_room;

  // RXF# is asynchronous; both flops idle high so reset never looks like data.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
    end else begin
      rxf_meta <= iRxF_n;
      rxf_s    <= rxf_meta;
    end
  end

  // Pointer MSB separates full from empty, so the difference is the level.
  assign level    = wr_ptr - rd_ptr;
  assign has_room = (level < PTR_W'(pDepth));
  assign oRxLevel = level;
  assign oRxValid = (level != '0);
  assign oRxData  = mem[rd_ptr[ADDR_W-1:0]];
  assign pop      = oRxValid && iRxReady;
  // The bus is sampled on the edge that ends the last RD# low cycle; the
  // FTDI has held the byte stable for the whole strobe, so no resync.
  assign push     = (state == ST_RD_LOW) && (cnt == '0);

  // Read handshake. Grant is only looked at in REQ: once RD# has fallen the
  // read always runs to completion, and the slot was reserved by has_room.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      oRx_n   <= 1'b1;
      oBusReq <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rxf_s && has_room) begin
            state   <= ST_REQ;
            oBusReq <= 1'b1;
          end
        end
        ST_REQ: begin
          if (iBusGnt) begin
            state <= ST_RD_LOW;
            oRx_n <= 1'b0;
            cnt   <= CNT_W'(pRdLowCycles - 1);
          end
        end
        ST_RD_LOW: begin
          if (cnt == '0) begin
            state <= ST_RD_HIGH;
            oRx_n <= 1'b1;
            cnt   <= CNT_W'(pRdHighCycles - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RD_HIGH: begin
          // Recovery lets the post-read RXF# reach rxf_s before IDLE looks
          // at it again, which prevents a phantom second read.
          if (cnt == '0) begin
            state   <= ST_IDLE;
            oBusReq <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          oRx_n   <= 1'b1;
          oBusReq <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; a byte in flight at reset is simply dropped.
  always_ff @(posedge iClk) begin
    if (push && !iRst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= iFifoData;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ftdi_rx_async.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ftdi_rx_async
//  Description : Self-checking bench for ftdi_rx_async. An FTDI behavioural
//                model feeds bytes from a queue; a scoreboard queue and a
//                byte count predict the FIFO contents and level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_rx_async;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LOWC  = 3;
  localparam int HIGHC = 3;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NRAND = 1500;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          rxf_n = 1'b1;
  logic          rx_n;
  logic          bus_req;
  logic          gnt = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          ready = 1'b0;
  logic [LW-1:0] rx_level;

  always #10 clk = ~clk;

  ftdi_rx_async #(
    .pDataWidth(DW), .pDepth(DEPTH), .pRdLowCycles(LOWC), .pRdHighCycles(HIGHC)
  ) dut (
    .iClk(clk), .iRst(rst), .iFifoData(fifo_data), .iRxF_n(rxf_n),
    .oRx_n(rx_n), .oBusReq(bus_req), .iBusGnt(gnt),
    .oRxData(rx_data), .oRxValid(rx_valid), .iRxReady(ready), .oRxLevel(rx_level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [DW-1:0] ftdi_q[$];   // bytes waiting inside the FTDI
  logic [DW-1:0] sb[$];       // bytes expected in the DUT FIFO, in order
  int   model_level = 0;
  int   reads = 0, falls = 0, pops = 0;
  int   hold = 0, low_cnt = 0, high_cnt = 1000, cyc = 0;
  int   t_rxf_fall = 0, t_req_rise = 0;
  logic prev_rx_n = 1'b1, prev_req = 1'b0, prev_gnt = 1'b0, rst_prev = 1'b1;

  // Monitor + FTDI model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst_prev) begin
      sb.delete();
      model_level = 0;
      low_cnt     = 0;
      high_cnt    = 1000;
      check("rst_rd_n",    32'(rx_n),     1);
      check("rst_bus_req", 32'(bus_req),  0);
      check("rst_valid",   32'(rx_valid), 0);
      check("rst_level",   32'(rx_level), 0);
    end else begin
      if (prev_rx_n === 1'b0 && rx_n === 1'b1) begin
        check("rd_low_width", 32'(low_cnt), LOWC);
        check("read_nonempty", 32'(ftdi_q.size() != 0), 1);
        if (ftdi_q.size() != 0) begin
          sb.push_back(ftdi_q.pop_front());
          model_level++;
        end
        reads++;
        hold     = int'($urandom_range(5, 2));
        high_cnt = 0;
      end
      if (prev_rx_n === 1'b1 && rx_n === 1'b0) begin
        check("rd_recovery", 32'(high_cnt >= HIGHC), 1);
        check("rd_after_gnt", 32'(prev_gnt), 1);
        check("rd_with_data", 32'(ftdi_q.size() != 0), 1);
        falls++;
        low_cnt = 0;
      end
      if (rx_n === 1'b0) begin
        low_cnt++;
        check("req_during_rd", 32'(bus_req), 1);
      end else begin
        high_cnt++;
      end
      if (!prev_req && bus_req === 1'b1) t_req_rise = cyc;
      check("level", 32'(rx_level), 32'(model_level));
      check("valid", 32'(rx_valid), 32'(model_level != 0));
      if (sb.size() != 0) check("data", 32'(rx_data), 32'(sb[0]));
    end
    // consumer handshake applied at the next rising edge
    if (rx_valid === 1'b1 && ready && sb.size() != 0) begin
      void'(sb.pop_front());
      model_level--;
      pops++;
    end
    // FTDI: RXF# high after each read for a while, low whenever data waits
    if (hold > 0) hold--;
    if (hold == 0 && ftdi_q.size() != 0) begin
      if (rxf_n) t_rxf_fall = cyc;
      rxf_n = 1'b0;
    end else begin
      rxf_n = 1'b1;
    end
    fifo_data = (ftdi_q.size() != 0) ? ftdi_q[0] : '0;
    prev_rx_n = rx_n;
    prev_req  = bus_req;
    prev_gnt  = gnt;
    rst_prev  = rst;
    cyc++;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_reads(input int target, input int budget);
    int n = 0;
    while (reads < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("wait_reads", 32'(reads >= target), 1);
  endtask

  task automatic wait_level(input int target, input int budget);
    int n = 0;
    while (model_level < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("wait_level", 32'(model_level >= target), 1);
  endtask

  task automatic wait_rd_low(input int budget);
    int n = 0;
    @(posedge clk); #2;
    while (rx_n !== 1'b0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check("wait_rd_low", 32'(rx_n === 1'b0), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    @(posedge clk); #2;
    ready = 1'b1;
    while ((ftdi_q.size() != 0 || sb.size() != 0 || bus_req !== 1'b0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(ftdi_q.size() == 0 && sb.size() == 0), 1);
    @(posedge clk); #2;
    ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, base_f, base_p, pushed, n, bias;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // single byte
    gnt  = 1'b1;
    base = reads;
    ftdi_q.push_back(8'hA5);
    wait_reads(base + 1, 100);
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    check("single_pulses", 32'(reads - base), 1);
    check("single_req_lat", 32'(t_req_rise - t_rxf_fall), 3);
    check("single_valid", 32'(rx_valid), 1);
    check("single_data", 32'(rx_data), 32'hA5);
    drain(100);

    // burst with consumer stalled
    base   = reads;
    base_p = pops;
    for (int i = 0; i < 20; i++) ftdi_q.push_back(8'(i));
    wait_level(16, 400);
    base_f = falls;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    check("burst_reads", 32'(reads - base), 16);
    check("burst_level", 32'(rx_level), 16);
    check("burst_no_rd", 32'(falls - base_f), 0);
    check("burst_rd_high", 32'(rx_n), 1);
    check("burst_rxf_low", 32'(rxf_n), 0);
    drain(800);
    check("burst_pops", 32'(pops - base_p), 20);

    // grant withheld, then lost mid-strobe
    @(posedge clk); #2;
    gnt  = 1'b0;
    base = reads;
    ftdi_q.push_back(8'h5A);
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    check("gnt_wait_req", 32'(bus_req), 1);
    check("gnt_wait_rd", 32'(rx_n), 1);
    @(posedge clk); #2;
    gnt = 1'b1;
    wait_rd_low(50);
    @(posedge clk); #2;
    gnt = 1'b0;
    wait_reads(base + 1, 20);
    @(negedge clk); #1;
    check("gnt_lost_data", 32'(rx_data), 32'h5A);
    check("gnt_lost_level", 32'(rx_level), 1);
    @(posedge clk); #2;
    gnt = 1'b1;
    drain(100);

    // simultaneous push and pop at level 1
    base = reads;
    ftdi_q.push_back(8'h11);
    wait_reads(base + 1, 100);
    repeat (10) @(posedge clk);
    #2 ftdi_q.push_back(8'h3C);
    wait_rd_low(50);
    @(posedge clk);
    @(posedge clk); #2;
    ready = 1'b1;
    @(posedge clk); #2;
    ready = 1'b0;
    @(negedge clk); #1;
    check("pp_level", 32'(rx_level), 1);
    check("pp_data", 32'(rx_data), 32'h3C);
    drain(100);

    // reset during the second RD# low cycle
    base = reads;
    ftdi_q.push_back(8'h77);
    wait_rd_low(50);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_rd_n", 32'(rx_n), 1);
    check("mid_rst_req", 32'(bus_req), 0);
    check("mid_rst_valid", 32'(rx_valid), 0);
    check("mid_rst_level", 32'(rx_level), 0);
    wait_reads(base + 1, 100);
    @(negedge clk); #1;
    check("mid_rst_reread", 32'(rx_data), 32'h77);
    drain(100);

    // randomized traffic
    pushed = 0;
    n      = 0;
    bias   = 4;
    while ((pushed < NRAND || ftdi_q.size() != 0) && n < 60000) begin
      @(posedge clk); #2;
      if (n % 500 == 0) bias = int'($urandom_range(8, 0));
      gnt   = ($urandom % 4) != 0;
      ready = ($urandom % 8) < 32'(bias);
      if (pushed < NRAND && ftdi_q.size() < 3 && ($urandom % 3) == 0) begin
        ftdi_q.push_back(8'($urandom));
        pushed++;
      end
      n++;
    end
    check("rand_done", 32'(pushed == NRAND && ftdi_q.size() == 0), 1);
    gnt = 1'b1;
    drain(400);
    check("end_sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
